// File: rtl/imm_extend_unit.sv
// Immediate extension unit: SIGN/ZERO/UPPER/BRANCH extension behind a 2-entry
// skid buffer. Define IMMX_COUNT_EN to add the 16-bit xfer_count output.
module imm_extend_unit #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  imm,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] ext_imm,
  output logic             out_neg
`ifdef IMMX_COUNT_EN
  ,
  output logic [15:0]      xfer_count
`endif
);

  localparam int EXT_W = OUT_W - IN_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

  state_t             state_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               out_neg_r;
  logic               skid_neg_r;
  logic [OUT_W-1:0]   oreg_r;
  logic [OUT_W-1:0]   skid_r;
  logic [OUT_W-1:0]   ext_s;
  logic               accept_s;
  logic               deliver_s;

  function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] raw,
                                               input logic [1:0] m);
    logic [OUT_W-1:0] sext;
    sext = {{EXT_W{raw[IN_W-1]}}, raw};
    case (m)
      2'b00:   extend = sext;
      2'b01:   extend = {{EXT_W{1'b0}}, raw};
      2'b10:   extend = {raw, {EXT_W{1'b0}}};
      2'b11:   extend = {sext[OUT_W-3:0], 2'b00};
      default: extend = sext;
    endcase
  endfunction

  assign accept_s  = in_valid && in_ready_r;
  assign deliver_s = out_valid_r && out_ready;
  assign ext_s     = extend(imm, mode);

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign ext_imm   = oreg_r;
  assign out_neg   = out_neg_r;

  // Buffer FSM; in_ready is precomputed from the next state so it never sees out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_neg_r   <= 1'b0;
      skid_neg_r  <= 1'b0;
      oreg_r      <= {OUT_W{1'b0}};
      skid_r      <= {OUT_W{1'b0}};
    end else begin
      case (state_r)
        ST_EMPTY: begin
          in_ready_r <= 1'b1;
          if (accept_s) begin
            oreg_r      <= ext_s;
            out_neg_r   <= imm[IN_W-1];
            out_valid_r <= 1'b1;
            state_r     <= ST_ONE;
          end
        end
        ST_ONE: begin
          in_ready_r <= 1'b1;
          if (accept_s && !deliver_s) begin
            skid_r     <= ext_s;
            skid_neg_r <= imm[IN_W-1];
            in_ready_r <= 1'b0;
            state_r    <= ST_FULL;
          end else if (accept_s && deliver_s) begin
            oreg_r    <= ext_s;
            out_neg_r <= imm[IN_W-1];
          end else if (deliver_s) begin
            out_valid_r <= 1'b0;
            state_r     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (deliver_s) begin
            oreg_r     <= skid_r;
            out_neg_r  <= skid_neg_r;
            in_ready_r <= 1'b1;
            state_r    <= ST_ONE;
          end else begin
            in_ready_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_EMPTY;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef IMMX_COUNT_EN
  logic [15:0] xfer_count_r;

  // Delivered-transfer counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_count_r <= 16'd0;
    end else if (deliver_s) begin
      xfer_count_r <= xfer_count_r + 16'd1;
    end
  end

  assign xfer_count = xfer_count_r;
`endif

endmodule

// File: doc/imm_extend_unit.md
IMM_EXTEND_UNIT -- requirements
Module: imm_extend_unit

Interface
REQ-001 SHALL have parameter IN_W, default 16, immediate input width.
REQ-002 SHALL have parameter OUT_W, default 32, extended output width; legal only when OUT_W >= IN_W+2.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream offers imm/mode.
REQ-006 SHALL have port in_ready  output  1  unit can accept this cycle.
REQ-007 SHALL have port imm  input  IN_W  raw immediate field.
REQ-008 SHALL have port mode  input  2  extension mode: 00 SIGN, 01 ZERO, 10 UPPER, 11 BRANCH.
REQ-009 SHALL have port out_valid  output  1  ext_imm holds a result.
REQ-010 SHALL have port out_ready  input  1  downstream consumes this cycle.
REQ-011 SHALL have port ext_imm  output  OUT_W  extended result.
REQ-012 SHALL have port out_neg  output  1  sign bit of the source imm for the presented result.

Function
REQ-013 SHALL accept a transfer on a rising edge where in_valid && in_ready, and SHALL deliver a transfer where out_valid && out_ready.
REQ-014 SHALL compute in SIGN mode: imm[IN_W-1] replicated into bits OUT_W-1..IN_W, with imm in the low bits.
REQ-015 SHALL compute in ZERO mode: zeros in bits OUT_W-1..IN_W, with imm in the low bits.
REQ-016 SHALL compute in UPPER mode: imm in bits OUT_W-1..OUT_W-IN_W, with zeros below.
REQ-017 SHALL compute in BRANCH mode: the SIGN-mode result shifted left 2, with the top 2 bits discarded and bits 1..0 zero.
REQ-018 SHALL compute the result combinationally at accept and register it; latency from accept to out_valid is exactly 1 cycle.
REQ-019 SHALL buffer results in a 2-entry store: output register (OREG) plus skid register (SKID); states EMPTY, ONE (OREG valid), FULL (OREG and SKID valid).
REQ-020 SHALL drive in_ready = 1 in EMPTY and ONE and 0 in FULL; in_ready is a registered function of state and SHALL NOT depend combinationally on out_ready.
REQ-021 SHALL make these transitions:
- EMPTY + accept -> ONE.
- ONE + accept with no deliver -> FULL, new result into SKID.
- ONE + deliver with no accept -> EMPTY.
- ONE + accept and deliver -> ONE, new result into OREG.
- FULL + deliver -> ONE, SKID moved into OREG.
- All other cases: hold.
REQ-022 SHALL hold ext_imm and out_neg stable while out_valid && !out_ready.
REQ-023 SHALL preserve order: results leave in accept order, with no loss or duplication under any in_valid/out_ready pattern.
REQ-024 SHALL ignore imm and mode when no accept occurs.

Reset
REQ-025 SHALL, on rst asserted (asynchronously), force state EMPTY, out_valid = 0, in_ready = 0, ext_imm = 0 and out_neg = 0.
REQ-026 SHALL drive in_ready = 1 on the first rising clk edge after rst deasserts.
REQ-027 SHALL discard any buffered results when rst is asserted mid-operation; no partial transfer is emitted afterwards.

Configuration
REQ-028 SHALL, with macro IMMX_COUNT_EN defined, add port xfer_count (output, 16 bits): the number of delivered transfers, reset to 0, incremented on each deliver, wrapping from 16'hFFFF to 0.
REQ-029 SHALL, without IMMX_COUNT_EN, have neither the xfer_count port nor its counter logic; all other behaviour is identical.

Verification
REQ-030 SHALL cover SIGN and ZERO with defaults: imm=16'h00FF, mode=00 -> ext_imm=32'h000000FF, out_neg=0; imm=16'hFFFF, mode=00 -> 32'hFFFFFFFF, out_neg=1; imm=16'h8000, mode=01 -> 32'h00008000.
REQ-031 SHALL cover UPPER and BRANCH: imm=16'h1234, mode=10 -> 32'h12340000; imm=16'hFFFE, mode=11 -> 32'hFFFFFFF8; imm=16'h4000, mode=11 -> 32'h00010000.
REQ-032 SHALL cover backpressure: out_ready=0 with 3 back-to-back offers of 16'h0001/0002/0003 in SIGN mode -> 2 accepted, in_ready=0; then out_ready=1 -> 32'h1, 32'h2, 32'h3 delivered in order; ext_imm stable throughout the stall.
REQ-033 SHALL cover throughput: in_valid=1 and out_ready=1 continuously for 8 cycles -> one result per cycle after a 1-cycle latency, with in_ready never dropping.
REQ-034 SHALL cover reset mid-operation: rst pulsed while FULL -> out_valid=0 immediately; no stale result appears after release.
REQ-035 SHALL cover the counter with IMMX_COUNT_EN: 5 deliveries -> xfer_count=5; with the counter preloaded to 16'hFFFF by deliveries, one more deliver -> 0.
REQ-036 SHALL cover parameters: a second instance with IN_W=12, OUT_W=24, imm=12'h800, mode=00 -> 24'hFFF800.
